ps2_device_tx: RTL and testbench

//  Device-side PS/2 transmitter, the keyboard/mouse end of the link read by USBReader.

---
 rtl/ps2_device_tx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: serialises one byte per request into an 11-bit frame on open-drain clk/data.
// Latency: IDLE_HOLD idle-bus cycles, then 22*HALF_PERIOD frame cycles plus HALF_PERIOD tail, then done pulse.
// Backpressure: send is accepted only while busy=0 (IDLE); host inhibit (clock held low) aborts the frame.
//
// Ports:
//   ck, reset            system clock (posedge), asynchronous active-low reset
//   send, data_in[7:0]   transmit request and byte to send
//   ps2_clk_in/data_in   sampled wired-AND PS/2 lines
//   ps2_clk_oe/data_oe   1 = pull the line low, 0 = release
//   busy, done, aborted  status; done/aborted are single-cycle pulses, busy drops with them
module ps2_device_tx #(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_HOLD   = 5000,
    parameter int CW          = 16
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_BIT_HI,
        S_BIT_LO,
        S_FINISH,
        S_ABORT
    } state_t;

    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] IH_LAST = CW'(IDLE_HOLD - 1);
    localparam logic [3:0]    IDX_STOP = 4'd10;

    state_t         r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [3:0]     r_idx, w_idx;
    logic [10:0]    r_frame, w_frame;
    logic           r_clk_oe, w_clk_oe;
    logic           r_data_oe, w_data_oe;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_aborted, w_aborted;

    logic           w_half_end;
    logic           w_bus_idle;

    assign w_half_end = (r_cnt == HP_LAST);
    assign w_bus_idle = ps2_clk_in & ps2_data_in;

    // Outputs are computed for the next state and registered, so every
    // line change lands exactly on a state boundary.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_frame   = r_frame;
        w_clk_oe  = r_clk_oe;
        w_data_oe = r_data_oe;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_aborted = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                if (send) begin
                    // stop, odd parity, data LSB..MSB, start; bit 0 goes out first
                    w_frame = {1'b1, ~^data_in, data_in, 1'b0};
                    w_idx   = 4'd0;
                    w_cnt   = '0;
                    w_busy  = 1'b1;
                    w_state = S_WAIT_BUS;
                end
            end

            S_WAIT_BUS: begin
                if (w_bus_idle) begin
                    if (r_cnt == IH_LAST) begin
                        w_cnt     = '0;
                        w_state   = S_BIT_HI;
                        w_clk_oe  = 1'b0;
                        w_data_oe = ~r_frame[r_idx];
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt = '0;
                end
            end

            S_BIT_HI: begin
                if (w_half_end) begin
                    w_cnt = '0;
                    // Clock still low while we release it means the host is inhibiting.
                    // Once the stop bit is on the wire the frame is treated as delivered.
                    if (!ps2_clk_in && (r_idx <= 4'd9)) begin
                        w_state   = S_ABORT;
                        w_clk_oe  = 1'b0;
                        w_data_oe = 1'b0;
                        w_aborted = 1'b1;
                        w_busy    = 1'b0;
                        w_frame   = '0;
                    end else begin
                        w_state  = S_BIT_LO;
                        w_clk_oe = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_BIT_LO: begin
                if (w_half_end) begin
                    w_cnt    = '0;
                    w_clk_oe = 1'b0;
                    if (r_idx == IDX_STOP) begin
                        w_state   = S_FINISH;
                        w_data_oe = 1'b0;
                    end else begin
                        // Data only moves while the clock is released.
                        w_idx     = r_idx + 4'd1;
                        w_state   = S_BIT_HI;
                        w_data_oe = ~r_frame[w_idx];
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_FINISH: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                if (w_half_end) begin
                    w_cnt   = '0;
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_ABORT: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                w_state   = S_IDLE;
            end

            default: begin
                w_state   = S_IDLE;
                w_cnt     = '0;
                w_idx     = 4'd0;
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= 4'd0;
            r_frame   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_frame   <= w_frame;
            r_clk_oe  <= w_clk_oe;
            r_data_oe <= w_data_oe;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_aborted <= w_aborted;
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a host-side timeline model predicts every output each cycle,
// with directed frame/parity/inhibit/idle-wait/reset scenarios plus a randomized phase.
// Host activity is modelled as wired-AND pulls on the clock and data lines.
module tb_ps2_device_tx;

    localparam int HP  = 4;
    localparam int IH  = 8;
    localparam int CW  = 16;
    localparam int BIT_CYC = 2 * HP;
    localparam int FRAME_CYC = 11 * BIT_CYC;

    logic       ck = 1'b0;
    logic       reset = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       host_clk_low = 1'b0;
    logic       host_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, aborted;

    assign ps2_clk_in  = ~ps2_clk_oe & ~host_clk_low;
    assign ps2_data_in = ~ps2_data_oe & ~host_data_low;

    ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_HOLD(IH), .CW(CW)) dut (
        .ck(ck), .reset(reset), .send(send), .data_in(data_in),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 ck = ~ck;

    // ---------------- reference model (timeline of a frame) ----------------
    bit         m_wait = 0, m_frm = 0;
    int         m_wcnt = 0, m_k = 0;
    logic [10:0] m_frame = '0;
    logic       e_clk_oe = 0, e_data_oe = 0, e_busy = 0, e_done = 0, e_aborted = 0;
    bit         lc, ld, prev_ab;

    always @(posedge ck or negedge reset) begin
        if (!reset) begin
            m_wait = 0; m_frm = 0; m_wcnt = 0; m_k = 0; m_frame = '0;
            e_clk_oe = 0; e_data_oe = 0; e_busy = 0; e_done = 0; e_aborted = 0;
        end else begin
            lc = !e_clk_oe && !host_clk_low;
            ld = !e_data_oe && !host_data_low;
            prev_ab = e_aborted;
            e_done = 0;
            e_aborted = 0;
            if (!m_wait && !m_frm && !prev_ab) begin
                if (send) begin
                    m_frame[0] = 1'b0;
                    for (int b = 0; b < 8; b++) m_frame[b+1] = data_in[b];
                    m_frame[9] = ($countones(data_in) % 2 == 0) ? 1'b1 : 1'b0;
                    m_frame[10] = 1'b1;
                    m_wait = 1; m_wcnt = 0; e_busy = 1;
                end
            end else if (m_wait) begin
                if (lc && ld) begin
                    m_wcnt++;
                    if (m_wcnt == IH) begin m_wait = 0; m_frm = 1; m_k = 0; end
                end else begin
                    m_wcnt = 0;
                end
            end else if (m_frm) begin
                if (m_k < FRAME_CYC && (m_k % BIT_CYC) == HP - 1 && (m_k / BIT_CYC) <= 9 && !lc) begin
                    m_frm = 0; e_aborted = 1; e_busy = 0;
                end else begin
                    m_k++;
                    if (m_k == FRAME_CYC + HP) begin m_frm = 0; e_done = 1; e_busy = 0; end
                end
            end
            if (m_frm && m_k < FRAME_CYC) begin
                e_clk_oe  = (m_k % BIT_CYC) >= HP;
                e_data_oe = !m_frame[m_k / BIT_CYC];
            end else begin
                e_clk_oe = 0; e_data_oe = 0;
            end
        end
    end

    // ---------------- checking and bookkeeping (single process) ----------------
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, t_busy = 0, lat = 0, n_done = 0, n_ab = 0, n_edges = 0, cap_n = 0;
    logic [10:0] cap = '0;
    logic prev_clk_oe = 0, prev_busy = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        logic [4:0] got, req;
        @(negedge ck);
        cyc++;
        got = {ps2_clk_oe, ps2_data_oe, busy, done, aborted};
        req = {e_clk_oe, e_data_oe, e_busy, e_done, e_aborted};
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL cycle%0d outputs{clk_oe,data_oe,busy,done,aborted}: got %b required %b", cyc, got, req);
        end
        if (ps2_clk_oe && !prev_clk_oe) begin
            n_edges++;
            if (cap_n < 11) cap[cap_n] = ~ps2_data_oe;
            cap_n++;
        end
        if (busy && !prev_busy) t_busy = cyc;
        if (done) begin n_done++; lat = cyc - t_busy; end
        if (aborted) n_ab++;
        prev_clk_oe = ps2_clk_oe;
        prev_busy = busy;
        @(posedge ck);
        #1;
    endtask

    task automatic do_send(input logic [7:0] d);
        data_in = d;
        send = 1'b1;
        cap_n = 0;
        cap = '0;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0;
        bit seen;
        d0 = n_done;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (n_done != d0) begin seen = 1; break; end
        end
        chk(nm, int'(seen), 1);
    endtask

    task automatic wait_k(input int k, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_frm && m_k == k) begin seen = 1; break; end
            tick();
        end
        chk(nm, int'(seen), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pd [3];
        int         pp [3];
        int         d0, a0, e0;
        int         hc, hd;
        pd[0] = 8'h00; pp[0] = 1;
        pd[1] = 8'hFF; pp[1] = 1;
        pd[2] = 8'h01; pp[2] = 0;

        // reset state
        tick(); tick();
        chk("reset_outputs", int'({ps2_clk_oe, ps2_data_oe, busy, done, aborted}), 0);
        reset = 1'b1;
        tick(); tick();

        // 1: basic frame 0x1C
        do_send(8'h1C);
        wait_done("t1_done");
        chk("t1_frame", int'(cap), 'h438);
        chk("t1_edges", cap_n, 11);
        chk("t1_latency", lat, IH + FRAME_CYC + HP);
        tick();
        chk("t1_busy_after", int'(busy), 0);

        // 2: parity
        for (int i = 0; i < 3; i++) begin
            do_send(pd[i]);
            wait_done("t2_done");
            chk("t2_parity", int'(cap[9]), pp[i]);
        end

        // 3: host inhibit during bit 4 -> abort, then 0xAA completes
        do_send(8'h1C);
        wait_k(4 * BIT_CYC, "t3_reach_bit4");
        a0 = n_ab;
        host_clk_low = 1'b1;
        repeat (5) tick();
        chk("t3_aborted", n_ab - a0, 1);
        chk("t3_edges_before", cap_n, 4);
        repeat (3) tick();
        host_clk_low = 1'b0;
        e0 = n_edges;
        repeat (20) tick();
        chk("t3_no_edges_after", n_edges - e0, 0);
        do_send(8'hAA);
        wait_done("t3_resend_done");
        chk("t3_resend_frame", int'(cap), 'h754);

        // 4: data held low 20 cycles, then a blip at count 7
        repeat (3) tick();
        data_in = 8'h1C;
        send = 1'b1;
        cap_n = 0;
        host_data_low = 1'b1;
        tick();
        send = 1'b0;
        repeat (19) tick();
        host_data_low = 1'b0;
        repeat (7) tick();
        host_data_low = 1'b1;
        tick();
        host_data_low = 1'b0;
        wait_done("t4_done");
        chk("t4_latency", lat, 19 + 7 + 1 + IH + FRAME_CYC + HP);
        chk("t4_frame", int'(cap), 'h438);

        // 5: second send mid-frame is ignored
        d0 = n_done;
        do_send(8'h1C);
        wait_k(5 * BIT_CYC, "t5_reach_bit5");
        data_in = 8'h55;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_done("t5_done");
        repeat (20) tick();
        chk("t5_frame", int'(cap), 'h438);
        chk("t5_done_count", n_done - d0, 1);

        // 6: reset during bit 6
        d0 = n_done;
        a0 = n_ab;
        do_send(8'h1C);
        wait_k(6 * BIT_CYC + HP + 1, "t6_reach_bit6");
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_release", int'({ps2_clk_oe, ps2_data_oe, busy}), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("t6_no_pulses", (n_done - d0) + (n_ab - a0), 0);
        do_send(8'h3C);
        wait_done("t6_resend_done");
        chk("t6_frame", int'(cap), 'h678);
        chk("t6_latency", lat, IH + FRAME_CYC + HP);

        // randomized traffic with host glitches and inhibits
        hc = 0;
        hd = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hc > 0) begin hc--; host_clk_low = 1'b1; end
            else begin
                host_clk_low = 1'b0;
                if ($urandom_range(0, 119) == 0) hc = $urandom_range(1, 6);
            end
            if (hd > 0) begin hd--; host_data_low = 1'b1; end
            else begin
                host_data_low = 1'b0;
                if ($urandom_range(0, 149) == 0) hd = $urandom_range(1, 4);
            end
            send = ($urandom_range(0, 29) == 0) && !e_aborted;
            data_in = 8'($urandom);
            tick();
        end
        send = 1'b0;
        host_clk_low = 1'b0;
        host_data_low = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
